// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: 2:1 arbiter for the 32-bit valid/ready memory port.
// m0 = instruction fetch, m1 = load/store, s_* = shared downstream slave.
// Grant is registered and held for the whole transaction (no preemption).
// Optional watchdog abort is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int unsigned FIXED_PRIO     = 0,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic        m0_write_en,
  input  logic [31:0] m0_addr,
  output logic [31:0] m0_rdata,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_byte_en,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic        m1_write_en,
  input  logic [31:0] m1_addr,
  output logic [31:0] m1_rdata,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_byte_en,
  output logic        s_valid,
  input  logic        s_ready,
  output logic        s_write_en,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_byte_en,
  input  logic [31:0] s_rdata
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  output logic        timeout_o
`endif
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  localparam logic [31:0] ABORT_RDATA = 32'hDEAD_BEEF;

  // Reject a watchdog limit too small to give the slave a single cycle
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 2");
  end

  state_t state;
  logic   last_gnt;
  logic   gnt_valid;
  logic   abort;
  logic   done;

  // Arbitration decision shared by IDLE and by back-to-back completion
  function automatic state_t pick(input logic v0, input logic v1, input logic lg);
    if (v0 && v1)  return ((FIXED_PRIO != 0) || lg) ? GNT0 : GNT1;
    else if (v0)   return GNT0;
    else if (v1)   return GNT1;
    else           return IDLE;
  endfunction

  // Valid of whichever master currently holds the grant
  always_comb begin
    gnt_valid = 1'b0;
    case (state)
      GNT0:    gnt_valid = m0_valid;
      GNT1:    gnt_valid = m1_valid;
      default: gnt_valid = 1'b0;
    endcase
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt;

  assign abort     = gnt_valid && !s_ready && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout_o = abort;

  // Watchdog: clears on grant entry, counts stalled granted cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   cnt <= '0;
    else if ((state == IDLE) || !gnt_valid || done) cnt <= '0;
    else                                       cnt <= cnt + CNT_W'(1);
  end
`else
  assign abort = 1'b0;
`endif

  assign done = gnt_valid && (s_ready || abort);

  // Grant FSM: chooses the next owner on idle or on completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
    end else begin
      case (state)
        IDLE: state <= pick(m0_valid, m1_valid, last_gnt);
        GNT0: begin
          if (!m0_valid) begin
            state <= IDLE;
          end else if (done) begin
            last_gnt <= 1'b0;
            if (FIXED_PRIO != 0) state <= pick(m0_valid, m1_valid, 1'b0);
            else                 state <= pick(m0_valid && !m1_valid, m1_valid, 1'b0);
          end
        end
        GNT1: begin
          if (!m1_valid) begin
            state <= IDLE;
          end else if (done) begin
            last_gnt <= 1'b1;
            if (FIXED_PRIO != 0) state <= pick(m0_valid, m1_valid, 1'b1);
            else                 state <= pick(m0_valid, m1_valid && !m0_valid, 1'b1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath mux: the granted master sees the slave, everything else is zero
  always_comb begin
    s_valid    = 1'b0;
    s_write_en = 1'b0;
    s_addr     = '0;
    s_wdata    = '0;
    s_byte_en  = '0;
    m0_ready   = 1'b0;
    m0_rdata   = '0;
    m1_ready   = 1'b0;
    m1_rdata   = '0;
    case (state)
      GNT0: begin
        s_valid    = m0_valid && !abort;
        s_write_en = m0_write_en;
        s_addr     = m0_addr;
        s_wdata    = m0_wdata;
        s_byte_en  = m0_byte_en;
        m0_ready   = s_ready || abort;
        m0_rdata   = abort ? ABORT_RDATA : s_rdata;
      end
      GNT1: begin
        s_valid    = m1_valid && !abort;
        s_write_en = m1_write_en;
        s_addr     = m1_addr;
        s_wdata    = m1_wdata;
        s_byte_en  = m1_byte_en;
        m1_ready   = s_ready || abort;
        m1_rdata   = abort ? ABORT_RDATA : s_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks for mem_port_arbiter.
// u_rr is round-robin, u_fp is fixed priority; both share the same inputs.
// Define MEM_ARB_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYCLES = 4).
module tb_mem_port_arbiter;

  logic        clk, rst;
  logic        m0_valid, m0_write_en, m1_valid, m1_write_en, s_ready;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, s_rdata;
  logic [3:0]  m0_byte_en, m1_byte_en;

  logic        m0_ready, m1_ready, s_valid, s_write_en, timeout;
  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
  logic [3:0]  s_byte_en;
  logic        fp_m0_ready, fp_m1_ready, fp_s_valid, fp_s_write_en, fp_timeout;
  logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_s_addr, fp_s_wdata;
  logic [3:0]  fp_s_byte_en;

  int nvec = 0;
  int nerr = 0;

  mem_port_arbiter #(.FIXED_PRIO(0), .TIMEOUT_CYCLES(4)) u_rr (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_write_en(m0_write_en),
    .m0_addr(m0_addr), .m0_rdata(m0_rdata), .m0_wdata(m0_wdata), .m0_byte_en(m0_byte_en),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_write_en(m1_write_en),
    .m1_addr(m1_addr), .m1_rdata(m1_rdata), .m1_wdata(m1_wdata), .m1_byte_en(m1_byte_en),
    .s_valid(s_valid), .s_ready(s_ready), .s_write_en(s_write_en), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_byte_en(s_byte_en), .s_rdata(s_rdata)
`ifdef MEM_ARB_TIMEOUT_EN
    , .timeout_o(timeout)
`endif
  );

  mem_port_arbiter #(.FIXED_PRIO(1), .TIMEOUT_CYCLES(4)) u_fp (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_ready(fp_m0_ready), .m0_write_en(m0_write_en),
    .m0_addr(m0_addr), .m0_rdata(fp_m0_rdata), .m0_wdata(m0_wdata), .m0_byte_en(m0_byte_en),
    .m1_valid(m1_valid), .m1_ready(fp_m1_ready), .m1_write_en(m1_write_en),
    .m1_addr(m1_addr), .m1_rdata(fp_m1_rdata), .m1_wdata(m1_wdata), .m1_byte_en(m1_byte_en),
    .s_valid(fp_s_valid), .s_ready(s_ready), .s_write_en(fp_s_write_en), .s_addr(fp_s_addr),
    .s_wdata(fp_s_wdata), .s_byte_en(fp_s_byte_en), .s_rdata(s_rdata)
`ifdef MEM_ARB_TIMEOUT_EN
    , .timeout_o(fp_timeout)
`endif
  );

`ifndef MEM_ARB_TIMEOUT_EN
  assign timeout    = 1'b0;
  assign fp_timeout = 1'b0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "tb time limit");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    m0_valid = 0; m0_write_en = 0; m0_addr = 0; m0_wdata = 0; m0_byte_en = 0;
    m1_valid = 0; m1_write_en = 0; m1_addr = 0; m1_wdata = 0; m1_byte_en = 0;
    s_ready = 0; s_rdata = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    #3;
    check("reset_s_valid", 32'(s_valid), 0);
    check("reset_m0_ready", 32'(m0_ready), 0);
    check("reset_m0_rdata", m0_rdata, 0);

    // Single read from m0
    do_reset();
    m0_valid = 1; m0_addr = 32'h100;
    @(negedge clk);
    check("rd_c0_s_valid", 32'(s_valid), 0);
    next_cycle();
    @(negedge clk);
    check("rd_c1_s_valid", 32'(s_valid), 1);
    check("rd_c1_s_addr", s_addr, 32'h100);
    check("rd_c1_m0_ready", 32'(m0_ready), 0);
    next_cycle();
    s_ready = 1; s_rdata = 32'h1234_5678;
    @(negedge clk);
    check("rd_c2_m0_ready", 32'(m0_ready), 1);
    check("rd_c2_m0_rdata", m0_rdata, 32'h1234_5678);
    check("rd_c2_m1_ready", 32'(m1_ready), 0);
    next_cycle();
    m0_valid = 0; s_ready = 0; s_rdata = 0;
    @(negedge clk);
    check("rd_c3_s_valid", 32'(s_valid), 0);
    check("rd_c3_m0_ready", 32'(m0_ready), 0);

    // Round-robin alternation with an always-ready slave
    do_reset();
    m0_valid = 1; m0_addr = 32'hA0; m1_valid = 1; m1_addr = 32'hB0; s_ready = 1;
    @(negedge clk);
    check("rr_c0_s_valid", 32'(s_valid), 0);
    for (int i = 1; i <= 4; i++) begin
      next_cycle();
      @(negedge clk);
      check("rr_s_addr", s_addr, (i % 2 == 1) ? 32'hA0 : 32'hB0);
      check("rr_m0_ready", 32'(m0_ready), (i % 2 == 1) ? 1 : 0);
      check("rr_m1_ready", 32'(m1_ready), (i % 2 == 1) ? 0 : 1);
    end

    // Fixed priority: m0 keeps the port while it requests
    do_reset();
    m0_valid = 1; m0_addr = 32'hA0; m1_valid = 1; m1_addr = 32'hB0; s_ready = 1;
    for (int i = 1; i <= 3; i++) begin
      next_cycle();
      @(negedge clk);
      check("fp_m0_ready", 32'(fp_m0_ready), 1);
      check("fp_m1_ready", 32'(fp_m1_ready), 0);
    end
    // m0 drops valid: stale m0 grant falls to IDLE, then m1 is granted
    next_cycle();
    m0_valid = 0;
    @(negedge clk);
    check("fp_drop_s_valid", 32'(fp_s_valid), 0);
    check("fp_drop_m1_ready", 32'(fp_m1_ready), 0);
    next_cycle();
    @(negedge clk);
    check("fp_idle_m1_ready", 32'(fp_m1_ready), 0);
    next_cycle();
    @(negedge clk);
    check("fp_m1_gnt_ready", 32'(fp_m1_ready), 1);
    check("fp_m1_gnt_addr", fp_s_addr, 32'hB0);

    // Write mux from m1 with a 3-cycle slave stall
    do_reset();
    m1_valid = 1; m1_write_en = 1; m1_addr = 32'h2000; m1_wdata = 32'hCAFE_F00D; m1_byte_en = 4'b0011;
    for (int i = 1; i <= 4; i++) begin
      next_cycle();
      s_ready = (i == 4);
      @(negedge clk);
      check("wr_s_valid", 32'(s_valid), 1);
      check("wr_s_write_en", 32'(s_write_en), 1);
      check("wr_s_addr", s_addr, 32'h2000);
      check("wr_s_wdata", s_wdata, 32'hCAFE_F00D);
      check("wr_s_byte_en", 32'(s_byte_en), 32'h3);
      check("wr_m0_ready", 32'(m0_ready), 0);
      check("wr_m1_ready", 32'(m1_ready), (i == 4) ? 1 : 0);
    end

    // Asynchronous reset while GNT1 stalls
    do_reset();
    m1_valid = 1; m1_addr = 32'h3000;
    next_cycle();
    @(negedge clk);
    check("ar_pre_s_valid", 32'(s_valid), 1);
    #2 s_ready = 1;
    #1;
    check("ar_pre_m1_ready", 32'(m1_ready), 1);
    rst = 1'b1;
    #1;
    check("ar_s_valid", 32'(s_valid), 0);
    check("ar_m1_ready", 32'(m1_ready), 0);
    s_ready = 0;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("ar_idle_s_valid", 32'(s_valid), 0);
    next_cycle();
    @(negedge clk);
    check("ar_regnt_s_valid", 32'(s_valid), 1);
    check("ar_regnt_s_addr", s_addr, 32'h3000);

`ifdef MEM_ARB_TIMEOUT_EN
    // Watchdog abort on the 4th stalled granted cycle
    do_reset();
    m0_valid = 1; m0_addr = 32'h400;
    for (int i = 1; i <= 3; i++) begin
      next_cycle();
      @(negedge clk);
      check("to_wait_m0_ready", 32'(m0_ready), 0);
      check("to_wait_timeout", 32'(timeout), 0);
      check("to_wait_s_valid", 32'(s_valid), 1);
    end
    next_cycle();
    @(negedge clk);
    check("to_m0_ready", 32'(m0_ready), 1);
    check("to_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
    check("to_timeout", 32'(timeout), 1);
    check("to_s_valid", 32'(s_valid), 0);
    next_cycle();
    m0_valid = 0;
    @(negedge clk);
    check("to_after_timeout", 32'(timeout), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
